// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause codes.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT  = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_PLL = 2'd1;
  localparam logic [1:0] CAUSE_BTN = 2'd2;
  localparam logic [1:0] CAUSE_SW  = 2'd3;

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchroniser plus stability counter for an asynchronous active-low button.
// The output follows the synced level only after it has been stable long enough.
module rst_debounce #(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int CNT_W        = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level
);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      // restart the stability window on the edge the synced value changes
      if (r_s1 != r_s2)
        r_cnt <= '0;
      else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1))
        r_level <= r_s2;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: waits for PLL lock, holds resets, then releases NUM_CH domains in
// ascending order with a fixed stagger; handles PLL loss, button and software resets.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int HOLD_CYC     = 32,
  parameter int STAGGER_CYC  = 16,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int CNT_W        = 16
) (
  input  logic              CLK100MHZ,
  input  logic              fpga_rst,
  input  logic              pll_locked_i,
  input  logic              btn_rst_n_i,
  input  logic [NUM_CH-1:0] sw_req_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              all_released_o,
  output logic [2:0]        state_o,
  output logic [1:0]        cause_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              r_lock_s1;
  logic              r_lock_s2;
  logic              r_btn_q;
  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_first_ch;
  logic [NUM_CH-1:0] r_rst_n;
  logic              r_all_rel;
  logic [1:0]        r_cause;

  logic              w_btn_db;
  logic              w_btn_fall;
  logic [CH_W-1:0]   w_sw_first;
  logic [NUM_CH-1:0] w_sw_keep;
  logic [NUM_CH-1:0] w_rel_hit;

  rst_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_btn_db (
    .i_clk  (CLK100MHZ),
    .i_rst  (fpga_rst),
    .i_async(btn_rst_n_i),
    .o_level(w_btn_db)
  );

  assign w_btn_fall = r_btn_q & ~w_btn_db;

  // lowest requesting channel wins; everything at or above it is re-sequenced
  always_comb begin
    w_sw_first = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (sw_req_i[k]) w_sw_first = CH_W'(k);
  end

  always_comb begin
    w_sw_keep = '0;
    w_rel_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sw_keep[k] = (k < int'(w_sw_first));
      w_rel_hit[k] = (k >= int'(r_first_ch)) &&
                     (r_cnt == CNT_W'((k - int'(r_first_ch)) * STAGGER_CYC));
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (fpga_rst) begin
      r_lock_s1  <= 1'b0;
      r_lock_s2  <= 1'b0;
      r_btn_q    <= 1'b1;
      r_state    <= ASSERT;
      r_cnt      <= '0;
      r_first_ch <= '0;
      r_rst_n    <= '0;
      r_all_rel  <= 1'b0;
      r_cause    <= CAUSE_POR;
    end else begin
      r_lock_s1 <= pll_locked_i;
      r_lock_s2 <= r_lock_s1;
      r_btn_q   <= w_btn_db;
      if (r_state != ASSERT && !r_lock_s2) begin
        r_state    <= ASSERT;
        r_rst_n    <= '0;
        r_all_rel  <= 1'b0;
        r_cnt      <= '0;
        r_first_ch <= '0;
        r_cause    <= CAUSE_PLL;
      end else if (r_state != ASSERT && w_btn_fall) begin
        r_state    <= HOLD;
        r_rst_n    <= '0;
        r_all_rel  <= 1'b0;
        r_cnt      <= '0;
        r_first_ch <= '0;
        r_cause    <= CAUSE_BTN;
      end else if (r_state == RUN && |sw_req_i) begin
        r_state    <= HOLD;
        r_rst_n    <= r_rst_n & w_sw_keep;
        r_all_rel  <= 1'b0;
        r_cnt      <= '0;
        r_first_ch <= w_sw_first;
        r_cause    <= CAUSE_SW;
      end else begin
        case (r_state)
          ASSERT: begin
            if (r_lock_s2) begin
              r_state <= HOLD;
              r_cnt   <= '0;
            end
          end
          HOLD: begin
            if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
              r_state <= RELEASE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          RELEASE: begin
            r_rst_n <= r_rst_n | w_rel_hit;
            r_cnt   <= r_cnt + 1'b1;
            if (w_rel_hit[NUM_CH-1]) begin
              r_state   <= RUN;
              r_all_rel <= 1'b1;
            end
          end
          RUN: ;
          default: r_state <= ASSERT;
        endcase
      end
    end
  end

  assign rst_n_o        = r_rst_n;
  assign all_released_o = r_all_rel;
  assign state_o        = r_state;
  assign cause_o        = r_cause;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq (3 channels, 8-cycle debounce): stimulus queues the
// expected output changes with their edge numbers, a monitor matches every change.
module tb_rst_seq;

  localparam int NCH = 3;

  logic           clk      = 1'b0;
  logic           fpga_rst = 1'b1;
  logic           lock     = 1'b1;
  logic           btn      = 1'b1;
  logic [NCH-1:0] sw       = '0;
  logic [NCH-1:0] rst_n;
  logic           all_rel;
  logic [2:0]     state;
  logic [1:0]     cause;

  rst_seq #(
    .NUM_CH      (NCH),
    .HOLD_CYC    (32),
    .STAGGER_CYC (16),
    .DEBOUNCE_CYC(8),
    .CNT_W       (16)
  ) dut (
    .CLK100MHZ     (clk),
    .fpga_rst      (fpga_rst),
    .pll_locked_i  (lock),
    .btn_rst_n_i   (btn),
    .sw_req_i      (sw),
    .rst_n_o       (rst_n),
    .all_released_o(all_rel),
    .state_o       (state),
    .cause_o       (cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [2:0] rst;
    logic       rel;
    logic [2:0] st;
    logic [1:0] ca;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic exp(input int c, input logic [2:0] r, input logic rl,
                     input logic [2:0] s, input logic [1:0] ca);
    ev_t e;
    e.c = c; e.rst = r; e.rel = rl; e.st = s; e.ca = ca;
    q.push_back(e);
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // every observable change must match the next queued event, including its edge
  bit         first = 1'b1;
  logic [8:0] prev;
  always @(negedge clk) begin
    logic [8:0] cur;
    ev_t        e;
    cur = {rst_n, all_rel, state, cause};
    if (first || cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_change cyc=%0d got rst_n=%b rel=%b st=%0d cause=%0d",
                 cyc, rst_n, all_rel, state, cause);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || cur !== {e.rst, e.rel, e.st, e.ca}) begin
          errors++;
          $display("FAIL event_at_%0d got cyc=%0d rst_n=%b rel=%b st=%0d cause=%0d, need rst_n=%b rel=%b st=%0d cause=%0d",
                   e.c, cyc, rst_n, all_rel, state, cause, e.rst, e.rel, e.st, e.ca);
        end
      end
      prev  = cur;
      first = 1'b0;
    end
  end

  initial begin
    // POR with lock already high: HOLD 3 edges after release, ch0 at +36
    exp(1,   3'b000, 0, 3'd0, 2'd0);
    exp(5,   3'b000, 0, 3'd1, 2'd0);
    exp(37,  3'b000, 0, 3'd2, 2'd0);
    exp(38,  3'b001, 0, 3'd2, 2'd0);
    exp(54,  3'b011, 0, 3'd2, 2'd0);
    exp(70,  3'b111, 1, 3'd3, 2'd0);
    at(2);   fpga_rst = 1'b0;

    // software reset of channels 1 and up; channel 0 untouched
    at(80);  sw = 3'b110;
    exp(81,  3'b001, 0, 3'd1, 2'd3);
    exp(113, 3'b001, 0, 3'd2, 2'd3);
    exp(114, 3'b011, 0, 3'd2, 2'd3);
    exp(130, 3'b111, 1, 3'd3, 2'd3);
    at(81);  sw = '0;
    at(90);  sw = 3'b001;
    at(91);  sw = '0;

    // 5-cycle glitch is filtered, then a long low press held past the sequence
    at(140); btn = 1'b0;
    at(145); btn = 1'b1;
    at(160); btn = 1'b0;
    exp(171, 3'b000, 0, 3'd1, 2'd2);
    exp(203, 3'b000, 0, 3'd2, 2'd2);
    exp(204, 3'b001, 0, 3'd2, 2'd2);
    exp(220, 3'b011, 0, 3'd2, 2'd2);
    exp(236, 3'b111, 1, 3'd3, 2'd2);
    at(250); btn = 1'b1;

    // lock loss 5 cycles into RELEASE, then a late lock
    at(260); sw = 3'b001;
    exp(261, 3'b000, 0, 3'd1, 2'd3);
    exp(293, 3'b000, 0, 3'd2, 2'd3);
    exp(294, 3'b001, 0, 3'd2, 2'd3);
    at(261); sw = '0;
    at(299); lock = 1'b0;
    exp(302, 3'b000, 0, 3'd0, 2'd1);
    at(400); lock = 1'b1;
    exp(403, 3'b000, 0, 3'd1, 2'd1);
    exp(435, 3'b000, 0, 3'd2, 2'd1);
    exp(436, 3'b001, 0, 3'd2, 2'd1);
    exp(452, 3'b011, 0, 3'd2, 2'd1);
    exp(468, 3'b111, 1, 3'd3, 2'd1);

    // synced lock loss and sw_req[0] seen on the same edge: PLL wins
    at(480); lock = 1'b0;
    exp(483, 3'b000, 0, 3'd0, 2'd1);
    at(482); sw = 3'b001;
    at(483); sw = '0;

    // fpga_rst mid-RELEASE forces reset values, then a clean restart
    at(490); lock = 1'b1;
    exp(493, 3'b000, 0, 3'd1, 2'd1);
    exp(525, 3'b000, 0, 3'd2, 2'd1);
    exp(526, 3'b001, 0, 3'd2, 2'd1);
    at(530); fpga_rst = 1'b1;
    exp(531, 3'b000, 0, 3'd0, 2'd0);
    at(533); fpga_rst = 1'b0;
    exp(536, 3'b000, 0, 3'd1, 2'd0);

    at(560);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d left (next at cyc %0d), need 0", q.size(), q[0].c);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
